writeback_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural integer register file.
- Selects the write-back value from the MEM/WB fields and commits it to the register file on the clock edge.
- Serves two combinational read ports to decode, with same-cycle write-through bypass.
- Exports the committed result to the EX forwarding unit and keeps a retire counter.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/regfile_core.sv | 64 ++++++
 rtl/writeback_regfile.sv | 75 +++++++
 tb/tb_writeback_regfile.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath sizes and the write-back source encoding
// used by the MEM/WB register, the control unit and the write-back stage.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_IMM  = 2'b10,
    WB_RSVD = 2'b11
  } wb_src_t;

  // True when the address names an implemented register (x0 included).
  function automatic logic reg_addr_ok(input logic [AW-1:0] addr);
    return (int'(addr) < NREG);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural integer register file: one write port, two combinational read
// ports with same-cycle write-through bypass, and a bypass-free debug port.
module regfile_core
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_dbg_data
);

  logic [XLEN-1:0] r_regs [NREG];

  // x0 and unimplemented addresses are never written, so r_regs[0] stays 0
  // after the first reset.
  logic w_wr_ok;
  assign w_wr_ok = i_we && (i_waddr != '0) && reg_addr_ok(i_waddr);

  // Clear the whole array on reset; otherwise commit the qualified write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Both decode read ports share the same rule; the bypass makes a value being
  // written this cycle visible to decode without waiting for the edge.
  logic [1:0][AW-1:0]   w_raddr;
  logic [1:0][XLEN-1:0] w_rdata;

  assign w_raddr[0] = i_rs1_addr;
  assign w_raddr[1] = i_rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic w_valid;
      logic w_hit;
      assign w_valid = !rst && (w_raddr[gi] != '0) && reg_addr_ok(w_raddr[gi]);
      assign w_hit   = w_wr_ok && (w_raddr[gi] == i_waddr);
      assign w_rdata[gi] = !w_valid ? '0 :
                           w_hit    ? i_wdata :
                                      r_regs[w_raddr[gi]];
    end
  endgenerate

  assign o_rs1_data = w_rdata[0];
  assign o_rs2_data = w_rdata[1];

  // Debug port shows the stored (pre-edge) value, never the bypass.
  assign o_dbg_data = (rst || !reg_addr_ok(i_dbg_addr)) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: selects the MEM/WB result, qualifies the commit, drives the
// register file, exports the committed value to EX forwarding and counts
// retired register writes.
module writeback_regfile
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] wb_aluRes,
  input  logic [XLEN-1:0] wb_signImm,
  input  logic [1:0]      wb_men2reg,
  input  logic            wb_reg_write,
  input  logic [AW-1:0]   wb_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_rd,
  output logic [XLEN-1:0] fwd_value,
  output logic [31:0]     retire_count,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] w_result;
  logic            w_commit;
  logic [31:0]     r_retire_count;

  // Write-back source select; the reserved encoding falls back to the ALU.
  always_comb begin
    w_result = wb_aluRes;
    case (wb_src_t'(wb_men2reg))
      WB_MEM:  w_result = wb_data;
      WB_IMM:  w_result = wb_signImm;
      default: w_result = wb_aluRes;
    endcase
  end

  // Writes to x0 are architecturally discarded and do not retire; a write in
  // a reset cycle is lost along with the flushed MEM/WB register.
  assign w_commit = wb_reg_write && (wb_rd != '0) && !rst;

  regfile_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_commit),
    .i_waddr    (wb_rd),
    .i_wdata    (w_result),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .i_dbg_addr (dbg_addr),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .o_dbg_data (dbg_data)
  );

  // Forwarding passes the fields straight through; consumers qualify on valid.
  assign fwd_valid = w_commit;
  assign fwd_rd    = wb_rd;
  assign fwd_value = rst ? '0 : w_result;

  // Count every committed write; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (w_commit) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus random
// traffic compared against an array-based architectural model.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] wb_data, wb_aluRes, wb_signImm;
  logic [1:0]  wb_men2reg;
  logic        wb_reg_write;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr, dbg_addr;
  logic [31:0] rs1_data, rs2_data, fwd_value, retire_count, dbg_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;

  writeback_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb_data      (wb_data),
    .wb_aluRes    (wb_aluRes),
    .wb_signImm   (wb_signImm),
    .wb_men2reg   (wb_men2reg),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_value    (fwd_value),
    .retire_count (retire_count),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  function automatic logic [31:0] model_result();
    if (wb_men2reg == 2'd1) return wb_data;
    if (wb_men2reg == 2'd2) return wb_signImm;
    return wb_aluRes;
  endfunction

  function automatic logic model_commit();
    return wb_reg_write && (wb_rd != 0) && !rst;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (rst || a == 0) return 32'd0;
    if (model_commit() && a == wb_rd) return model_result();
    return model_regs[a];
  endfunction

  task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] imm);
    wb_reg_write = we;
    wb_rd        = rd;
    wb_men2reg   = sel;
    wb_aluRes    = alu;
    wb_data      = mem;
    wb_signImm   = imm;
    #1;
  endtask

  // Advance one clock edge and apply the architectural effect to the model.
  task automatic tick();
    logic        c;
    logic [31:0] r;
    logic        rr;
    c  = model_commit();
    r  = model_result();
    rr = rst;
    @(posedge clk);
    if (rr) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (c) begin
      model_regs[wb_rd] = r;
      model_count = model_count + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rs1_addr = 5'd9; rs2_addr = 5'd9; dbg_addr = 5'd9;
    drive(1'b1, 5'd9, 2'd0, 32'h1111_2222, 32'h3, 32'h4);
    n_checks++;
    if (rs1_data !== 0 || rs2_data !== 0 || dbg_data !== 0 || fwd_value !== 0 || fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs rs1=%h rs2=%h dbg=%h fwdv=%h fwd_valid=%b required all 0", rs1_data, rs2_data, dbg_data, fwd_value, fwd_valid);
    end
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (retire_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count got=%h exp=0", retire_count);
    end
    n_checks++;
    if (dbg_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_reg9 got=%h exp=0", dbg_data);
    end
    $display("txn reset: outputs zero, count=%0d", retire_count);
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'hBAD0_0001, 32'hBAD0_0002);
    tick();
    rs1_addr = 5'd5;
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (rs1_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL write_read got=%h exp=12345678", rs1_data);
    end
    n_checks++;
    if (retire_count !== 32'd1) begin
      n_fail++;
      $display("FAIL write_count got=%0d exp=1", retire_count);
    end
    $display("txn write x5: rs1=%h count=%0d", rs1_data, retire_count);
  endtask

  task automatic test_bypass();
    rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
    drive(1'b1, 5'd7, 2'd1, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0022);
    n_checks++;
    if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_both rs1=%h rs2=%h exp=deadbeef", rs1_data, rs2_data);
    end
    n_checks++;
    if (dbg_data !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass_dbg_old got=%h exp=0", dbg_data);
    end
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_value !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_fwd valid=%b rd=%0d val=%h exp 1/7/deadbeef", fwd_valid, fwd_rd, fwd_value);
    end
    tick();
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (dbg_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_dbg_new got=%h exp=deadbeef", dbg_data);
    end
    $display("txn bypass x7: dbg=%h", dbg_data);
  endtask

  task automatic test_x0();
    logic [31:0] cnt_before;
    cnt_before = retire_count;
    rs1_addr = 5'd0; dbg_addr = 5'd0;
    drive(1'b1, 5'd0, 2'd2, 32'h5, 32'h6, 32'hFFFF_F000);
    n_checks++;
    if (rs1_data !== 32'd0 || fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_read rs1=%h fwd_valid=%b exp 0/0", rs1_data, fwd_valid);
    end
    n_checks++;
    if (fwd_value !== 32'hFFFF_F000 || fwd_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL x0_fwd_pass val=%h rd=%0d exp fffff000/0", fwd_value, fwd_rd);
    end
    tick();
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (retire_count !== cnt_before || dbg_data !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_nocommit count=%0d exp=%0d dbg=%h exp=0", retire_count, cnt_before, dbg_data);
    end
    $display("txn write x0: count=%0d", retire_count);
  endtask

  task automatic test_src_rsvd();
    drive(1'b1, 5'd3, 2'd3, 32'hA5A5_A5A5, 32'h1, 32'h2);
    tick();
    rs2_addr = 5'd3;
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (rs2_data !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL src_rsvd got=%h exp=a5a5a5a5", rs2_data);
    end
    $display("txn sel=11 x3: rs2=%h", rs2_data);
  endtask

  task automatic test_random();
    int errs;
    for (int it = 0; it < 120; it++) begin
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) rs1_addr = wb_rd;
      #1;
      errs = 0;
      n_checks++;
      if (rs1_data !== model_read(rs1_addr)) begin
        errs++;
        $display("FAIL rand_rs1 it=%0d a=%0d got=%h exp=%h", it, rs1_addr, rs1_data, model_read(rs1_addr));
      end
      n_checks++;
      if (rs2_data !== model_read(rs2_addr)) begin
        errs++;
        $display("FAIL rand_rs2 it=%0d a=%0d got=%h exp=%h", it, rs2_addr, rs2_data, model_read(rs2_addr));
      end
      n_checks++;
      if (dbg_data !== model_regs[dbg_addr]) begin
        errs++;
        $display("FAIL rand_dbg it=%0d a=%0d got=%h exp=%h", it, dbg_addr, dbg_data, model_regs[dbg_addr]);
      end
      n_checks++;
      if (fwd_valid !== model_commit() || fwd_rd !== wb_rd || fwd_value !== model_result()) begin
        errs++;
        $display("FAIL rand_fwd it=%0d valid=%b rd=%0d val=%h exp %b/%0d/%h", it, fwd_valid, fwd_rd, fwd_value,
                 model_commit(), wb_rd, model_result());
      end
      tick();
      n_checks++;
      if (retire_count !== model_count) begin
        errs++;
        $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, retire_count, model_count);
      end
      n_fail += errs;
      $display("txn rand %0d: we=%b rd=%0d sel=%0d count=%0d", it, wb_reg_write, wb_rd, wb_men2reg, retire_count);
    end
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_midstream();
    int errs;
    for (int r = 1; r < 32; r++) begin
      drive(1'b1, 5'(r), 2'd0, 32'(r), 32'd0, 32'd0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 5'd9, 2'd0, 32'h99, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    errs = 0;
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r); dbg_addr = 5'(r);
      #1;
      if (rs1_data !== 32'd0 || dbg_data !== 32'd0) begin
        errs++;
        $display("FAIL midreset_reg x%0d rs1=%h dbg=%h exp=0", r, rs1_data, dbg_data);
      end
    end
    n_checks++;
    if (errs != 0) n_fail++;
    n_checks++;
    if (retire_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_count got=%0d exp=0", retire_count);
    end
    $display("txn reset mid-stream: count=%0d", retire_count);
  endtask

  task automatic test_wrap();
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    model_count = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload got=%h exp=ffffffff", retire_count);
    end
    drive(1'b1, 5'd12, 2'd0, 32'h12, 32'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (retire_count !== model_count) begin
      n_fail++;
      $display("FAIL wrap_zero got=%h exp=%h", retire_count, model_count);
    end
    drive(1'b1, 5'd13, 2'd1, 32'd0, 32'h13, 32'd0);
    tick();
    drive(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (retire_count !== model_count) begin
      n_fail++;
      $display("FAIL wrap_next got=%h exp=%h", retire_count, model_count);
    end
    $display("txn counter wrap: count=%0d", retire_count);
  endtask

  initial begin
    rst = 1'b1;
    wb_data = 0; wb_aluRes = 0; wb_signImm = 0; wb_men2reg = 0;
    wb_reg_write = 0; wb_rd = 0; rs1_addr = 0; rs2_addr = 0; dbg_addr = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 32'd0;
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_src_rsvd();
    test_random();
    test_reset_midstream();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
